// File: rtl/lion_mem_bridge.sv
// Bridges a valid/ready core memory port onto a single-port synchronous SRAM,
// with optional wait states and an out-of-range bus error response.
module lion_mem_bridge #(
    parameter int ADDR_WIDTH  = 14,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  bus_err,
    output logic                  sram_en,
    output logic [3:0]            sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } stateT;

    // The counter is loaded one short because the cycle it reaches zero is the last WAIT cycle.
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    stateT                 r_state;
    stateT                 w_nextState;
    logic [3:0]            r_waitCnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_instr;
    logic                  r_oor;
    logic                  w_accept;
    logic                  w_oor;
    logic                  w_unusedInstr;

    assign w_accept      = (r_state == IDLE) && mem_valid;
    assign w_oor         = |(mem_addr >> (ADDR_WIDTH + 2));
    assign w_unusedInstr = &{1'b0, r_instr};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (mem_valid) begin
                    w_nextState = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (r_waitCnt == 4'd0) begin
                    w_nextState = ACCESS;
                end
            end
            ACCESS:  w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Request fields are frozen at acceptance so the core may change or drop them afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_waitCnt <= 4'd0;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_instr   <= 1'b0;
            r_oor     <= 1'b0;
        end else if (w_accept) begin
            r_waitCnt <= WAIT_LOAD;
            r_addr    <= mem_addr[ADDR_WIDTH+1:2];
            r_wdata   <= mem_wdata;
            r_wstrb   <= mem_wstrb;
            r_instr   <= mem_instr;
            r_oor     <= w_oor;
        end else if ((r_state == WAIT) && (r_waitCnt != 4'd0)) begin
            r_waitCnt <= r_waitCnt - 4'd1;
        end
    end

    always_comb begin
        sram_en   = 1'b0;
        sram_we   = 4'd0;
        mem_ready = 1'b0;
        bus_err   = 1'b0;
        mem_rdata = 32'd0;
        if ((r_state == ACCESS) && !r_oor) begin
            sram_en = 1'b1;
            sram_we = r_wstrb;
        end
        if (r_state == RESP) begin
            mem_ready = 1'b1;
            bus_err   = r_oor;
            if (!r_oor && (r_wstrb == 4'd0)) begin
                mem_rdata = sram_rdata;
            end
        end
    end

    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;

endmodule

// File: tb/tb_lion_mem_bridge.sv
// Two bridges (no wait states, three wait states) against a behavioural SRAM,
// checked by a reference memory model and an expected-response queue.
module tb_lion_mem_bridge;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } expT;

    logic        clock;
    logic        reset;
    logic        memValid   [2];
    logic        memInstr   [2];
    logic [31:0] memAddr    [2];
    logic [31:0] memWdata   [2];
    logic [3:0]  memWstrb   [2];
    logic        memReady   [2];
    logic [31:0] memRdata   [2];
    logic        busErr     [2];
    logic        sramEn     [2];
    logic [3:0]  sramWe     [2];
    logic [13:0] sramAddr   [2];
    logic [31:0] sramWdata  [2];
    logic [31:0] sramRdata  [2];

    logic [31:0] sramMem [2][16384];
    logic [31:0] refMem  [2][16384];
    bit          memInit;
    int          cyc;
    int          totalCnt;
    int          badCnt;
    expT         expQ[$];

    lion_mem_bridge #(.ADDR_WIDTH(14), .WAIT_STATES(0)) u0 (
        .clock(clock), .reset(reset),
        .mem_valid(memValid[0]), .mem_instr(memInstr[0]), .mem_addr(memAddr[0]),
        .mem_wdata(memWdata[0]), .mem_wstrb(memWstrb[0]), .mem_ready(memReady[0]),
        .mem_rdata(memRdata[0]), .bus_err(busErr[0]), .sram_en(sramEn[0]),
        .sram_we(sramWe[0]), .sram_addr(sramAddr[0]), .sram_wdata(sramWdata[0]),
        .sram_rdata(sramRdata[0])
    );

    lion_mem_bridge #(.ADDR_WIDTH(14), .WAIT_STATES(3)) u3 (
        .clock(clock), .reset(reset),
        .mem_valid(memValid[1]), .mem_instr(memInstr[1]), .mem_addr(memAddr[1]),
        .mem_wdata(memWdata[1]), .mem_wstrb(memWstrb[1]), .mem_ready(memReady[1]),
        .mem_rdata(memRdata[1]), .bus_err(busErr[1]), .sram_en(sramEn[1]),
        .sram_we(sramWe[1]), .sram_addr(sramAddr[1]), .sram_wdata(sramWdata[1]),
        .sram_rdata(sramRdata[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] initWord(input int k, input int i);
        logic [31:0] w;
        w = {16'(i), 16'(16'h5A00 + k)};
        if (i == 4) w = 32'hDEADBEEF;
        return w;
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // Synchronous SRAM: read data appears the cycle after an enabled access.
    always @(posedge clock) begin
        if (!memInit) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 16384; i++) sramMem[k][i] <= initWord(k, i);
                sramRdata[k] <= 32'd0;
            end
            memInit <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (sramEn[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sramWe[k][b]) sramMem[k][sramAddr[k]][8*b +: 8] <= sramWdata[k][8*b +: 8];
                    end
                    sramRdata[k] <= sramMem[k][sramAddr[k]];
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // lead=1 when valid is already high in the RESP cycle of the previous request.
    task automatic applyStimulus(input int k, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input bit perturb, input bit keepValid,
                                 input int lead, output int readyCyc);
        expT e;
        expT got;
        int  n;
        int  ws;
        bit  oor;
        bit  seen;
        ws   = (k == 1) ? 3 : 0;
        oor  = (a[31:16] != 16'd0);
        e.err   = oor;
        e.rdata = (!oor && s == 4'd0) ? refMem[k][a[15:2]] : 32'd0;
        expQ.push_back(e);
        if (!oor) refMem[k][a[15:2]] = mergeBytes(refMem[k][a[15:2]], d, s);
        memValid[k] = 1'b1;
        memInstr[k] = s[0];
        memAddr[k]  = a;
        memWdata[k] = d;
        memWstrb[k] = s;
        n = 0;
        seen = 1'b0;
        readyCyc = 0;
        while (!seen && n < 30) begin
            @(posedge clock);
            #1;
            n++;
            if (perturb && n == lead + 1) begin
                memValid[k] = 1'b0;
                memAddr[k]  = ~a;
                memWdata[k] = ~d;
                memWstrb[k] = ~s;
            end
            if (n == ws + 1 + lead) begin
                checkOutput("accessEn", 32'(sramEn[k]), 32'(!oor));
                checkOutput("accessWe", 32'(sramWe[k]), oor ? 32'd0 : 32'(s));
                if (!oor) begin
                    checkOutput("accessAddr", 32'(sramAddr[k]), 32'(a[15:2]));
                    checkOutput("accessWdata", sramWdata[k], d);
                end
            end else if (oor) begin
                checkOutput("oorEnIdle", 32'(sramEn[k]), 32'd0);
            end
            if (memReady[k]) begin
                seen = 1'b1;
                readyCyc = cyc;
                checkOutput("latency", 32'(n), 32'(ws + 2 + lead));
                got = expQ.pop_front();
                checkOutput("rdata", memRdata[k], got.rdata);
                checkOutput("busErr", 32'(busErr[k]), 32'(got.err));
            end
        end
        if (!seen) begin
            checkOutput("readyTimeout", 32'd0, 32'd1);
            void'(expQ.pop_front());
        end
        if (!keepValid) begin
            memValid[k] = 1'b0;
            @(posedge clock);
            #1;
            checkOutput("readyPulse", 32'(memReady[k]), 32'd0);
        end
    endtask

    initial begin
        int c0;
        int c1;
        int k;
        logic [31:0] a;
        reset = 1'b1;
        for (int j = 0; j < 2; j++) begin
            memValid[j] = 1'b0;
            memInstr[j] = 1'b0;
            memAddr[j]  = 32'd0;
            memWdata[j] = 32'd0;
            memWstrb[j] = 4'd0;
            for (int i = 0; i < 16384; i++) refMem[j][i] = initWord(j, i);
        end
        repeat (3) @(posedge clock);
        #1;
        for (int j = 0; j < 2; j++) begin
            checkOutput("rstReady", 32'(memReady[j]), 32'd0);
            checkOutput("rstRdata", memRdata[j], 32'd0);
            checkOutput("rstErr", 32'(busErr[j]), 32'd0);
            checkOutput("rstEn", 32'(sramEn[j]), 32'd0);
            checkOutput("rstWe", 32'(sramWe[j]), 32'd0);
            checkOutput("rstAddr", 32'(sramAddr[j]), 32'd0);
            checkOutput("rstWdata", sramWdata[j], 32'd0);
        end
        reset = 1'b0;

        applyStimulus(0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b0, 0, c0);
        applyStimulus(0, 32'h0000_0104, 32'h1234_5678, 4'b0011, 1'b0, 1'b0, 0, c0);
        applyStimulus(0, 32'h0000_0104, 32'h0, 4'h0, 1'b0, 1'b0, 0, c0);
        applyStimulus(0, 32'h0001_0000, 32'hAAAA_5555, 4'hF, 1'b0, 1'b0, 0, c0);
        applyStimulus(0, 32'h8000_0020, 32'h0, 4'h0, 1'b0, 1'b0, 0, c0);
        applyStimulus(0, 32'h0000_0013, 32'h0, 4'h0, 1'b0, 1'b0, 0, c0);
        applyStimulus(0, 32'h0000_0300, 32'h0BAD_F00D, 4'b1100, 1'b1, 1'b0, 0, c0);
        applyStimulus(0, 32'h0000_0300, 32'h0, 4'h0, 1'b0, 1'b0, 0, c0);

        applyStimulus(1, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b0, 0, c0);
        applyStimulus(1, 32'h0000_0040, 32'h0, 4'h0, 1'b0, 1'b1, 0, c0);
        applyStimulus(1, 32'h0000_0044, 32'h0, 4'h0, 1'b0, 1'b0, 1, c1);
        checkOutput("b2bSpacing", 32'(c1 - c0), 32'd6);
        applyStimulus(1, 32'h0000_FFFC, 32'hFEED_FACE, 4'b1001, 1'b1, 1'b0, 0, c0);
        applyStimulus(1, 32'h0000_FFFC, 32'h0, 4'h0, 1'b0, 1'b0, 0, c0);
        applyStimulus(1, 32'h0002_0000, 32'h0, 4'h0, 1'b0, 1'b0, 0, c0);

        // Reset during the ACCESS cycle of a write must leave the SRAM untouched.
        memValid[0] = 1'b1;
        memAddr[0]  = 32'h0000_0200;
        memWdata[0] = 32'hCAFE_F00D;
        memWstrb[0] = 4'hF;
        @(posedge clock);
        #1;
        checkOutput("preRstEn", 32'(sramEn[0]), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midRstEn", 32'(sramEn[0]), 32'd0);
        checkOutput("midRstWe", 32'(sramWe[0]), 32'd0);
        checkOutput("midRstAddr", 32'(sramAddr[0]), 32'd0);
        memValid[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checkOutput("midRstReady", 32'(memReady[0]), 32'd0);
        end
        reset = 1'b0;
        applyStimulus(0, 32'h0000_0200, 32'h0, 4'h0, 1'b0, 1'b0, 0, c0);

        for (int i = 0; i < 10; i++) begin
            k = int'($urandom_range(0, 1));
            a = {16'd0, 16'($urandom_range(0, 65535))};
            if ($urandom_range(0, 4) == 0) a[31:16] = 16'($urandom_range(1, 65535));
            applyStimulus(k, a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          1'b0, 0, c0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i % 2, 32'h0000_0104, 32'h0, 4'h0, 1'b0, 1'b0, 0, c0);
        end

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule

// File: doc/lion_mem_bridge.md
LION_MEM_BRIDGE -- requirements
Module: lion_mem_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14: word-address bits of the SRAM (64 KiB).
REQ-002 SHALL have parameter WAIT_STATES, default 0: extra idle cycles inserted before each SRAM access (0..15).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port mem_valid  in  1  core request, held until mem_ready.
REQ-007 SHALL have port mem_instr  in  1  instruction-fetch tag, captured but functionally ignored.
REQ-008 SHALL have port mem_addr  in  32  byte address.
REQ-009 SHALL have port mem_wdata  in  32  write data.
REQ-010 SHALL have port mem_wstrb  in  4  byte write enables; 0 = read.
REQ-011 SHALL have port mem_ready  out  1  one-cycle completion pulse.
REQ-012 SHALL have port mem_rdata  out  32  read data, valid only while mem_ready=1.
REQ-013 SHALL have port bus_err  out  1  one-cycle pulse coincident with mem_ready for out-of-range access.
REQ-014 SHALL have port sram_en  out  1  synchronous SRAM enable.
REQ-015 SHALL have port sram_we  out  4  SRAM byte write enables.
REQ-016 SHALL have port sram_addr  out  ADDR_WIDTH  SRAM word address.
REQ-017 SHALL have port sram_wdata  out  32  SRAM write data.
REQ-018 SHALL have port sram_rdata  in  32  SRAM read data, valid one cycle after an enabled read.

Function
REQ-019 SHALL implement an FSM with states IDLE, WAIT, ACCESS, RESP.
REQ-020 In IDLE, when mem_valid=1: SHALL capture mem_addr, mem_wdata, mem_wstrb, mem_instr, then go to WAIT if WAIT_STATES>0, else to ACCESS.
REQ-021 WAIT SHALL last exactly WAIT_STATES cycles, counted by a 4-bit down-counter, then go to ACCESS.
REQ-022 ACCESS SHALL last one cycle, then go to RESP; RESP SHALL last one cycle, then go to IDLE.
REQ-023 Request latency SHALL be exactly WAIT_STATES+2 cycles, from the cycle mem_valid is first sampled in IDLE to the mem_ready cycle.
REQ-024 Range check: a request SHALL be out of range when captured addr[31:ADDR_WIDTH+2] != 0.
REQ-025 For an in-range request, during ACCESS: sram_en=1, sram_addr=addr[ADDR_WIDTH+1:2], sram_wdata=captured wdata, sram_we=captured wstrb.
REQ-026 For an out-of-range request, sram_en and sram_we SHALL remain 0 throughout.
REQ-027 In all states other than in-range ACCESS: sram_en=0 and sram_we=0; sram_addr and sram_wdata SHALL hold the last captured values.
REQ-028 In RESP: mem_ready=1; mem_rdata=sram_rdata for an in-range read, else 0.
REQ-029 In RESP: bus_err=1 iff the request is out of range.
REQ-030 Outside RESP: mem_ready=0, mem_rdata=0, bus_err=0.
REQ-031 addr[1:0] SHALL be ignored.
REQ-032 Changes to mem_* inputs after capture SHALL be ignored until IDLE is re-entered.
REQ-033 mem_valid deasserting mid-transaction SHALL NOT abort the transaction; it completes normally.
REQ-034 No new request SHALL be accepted in the RESP cycle; minimum spacing between mem_ready pulses is WAIT_STATES+3 cycles.

Reset
REQ-035 On reset assertion, state SHALL return to IDLE asynchronously and the wait counter SHALL clear.
REQ-036 While reset is asserted, all outputs SHALL be 0.
REQ-037 Reset asserted during ACCESS SHALL drop sram_en/sram_we within the same cycle; no write completes on any edge where reset is high.
REQ-038 The first request after reset deasserts SHALL be accepted on the first rising edge with reset=0 and mem_valid=1.

Verification
REQ-039 Read scenario (WAIT_STATES=0): mem_valid=1, addr=0x0000_0010, wstrb=0, sram_rdata=0xDEADBEEF in cycle 2 -> sram_en=1 with sram_addr=4 in cycle 1; mem_ready=1, mem_rdata=0xDEADBEEF, bus_err=0 in cycle 2.
REQ-040 Write scenario: addr=0x0000_0104, wdata=0x1234_5678, wstrb=4'b0011 -> one ACCESS cycle with sram_we=4'b0011, sram_addr=0x41, sram_wdata=0x12345678; mem_ready pulse with mem_rdata=0.
REQ-041 Out-of-range scenario (ADDR_WIDTH=14): addr=0x0001_0000, write -> sram_en never asserted; mem_ready=1 and bus_err=1 in the same cycle.
REQ-042 Wait-state scenario (WAIT_STATES=3): read -> mem_ready exactly 5 cycles after acceptance; back-to-back requests -> mem_ready pulses spaced exactly 6 cycles apart.
REQ-043 Reset-mid-op scenario: assert reset during ACCESS of a write -> sram_en/sram_we fall the same cycle, mem_ready never pulses, and the next request after release completes with nominal latency.
